// File: rtl/serial_crc8_if.sv
// Bit-serial stream interface for serial_crc8: input bit handshake plus the
// framed output stream (data pass-through followed by CRC bits).
interface serial_crc8_if;
  logic       in_valid;
  logic       in_bit;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic       out_bit;
  logic       out_crc_phase;
  logic       frame_done;
  logic [7:0] crc;

  modport master (
    output in_valid, in_bit, in_last,
    input  in_ready, out_valid, out_bit, out_crc_phase, frame_done, crc
  );

  modport slave (
    input  in_valid, in_bit, in_last,
    output in_ready, out_valid, out_bit, out_crc_phase, frame_done, crc
  );
endinterface

// File: rtl/serial_crc8.sv
// Serial CRC-8 framer: echoes each accepted data bit one cycle later, then
// appends the 8-bit CRC of the frame MSB first and pulses frame_done.
module serial_crc8 #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input logic         clk,
  input logic         rst_n,
  serial_crc8_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA, CRC_OUT} state_t;

  state_t     state, state_nxt;
  logic [7:0] crc_q;
  logic [2:0] cnt_q;
  logic       accept;
  logic       vld_p1;
  logic       bit_p1;
  logic       crc_phase_p1;
  logic       done_p1;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  endfunction

  assign accept = bus.in_valid && (state != CRC_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DATA: begin
        if (accept) state_nxt = bus.in_last ? CRC_OUT : DATA;
      end
      CRC_OUT: begin
        if (cnt_q == 3'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered output stream. crc_q is frozen during CRC_OUT and
  // serves as the snapshot that cnt_q indexes from bit 7 down to bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q        <= INIT;
      cnt_q        <= 3'd0;
      vld_p1       <= 1'b0;
      bit_p1       <= 1'b0;
      crc_phase_p1 <= 1'b0;
      done_p1      <= 1'b0;
    end else begin
      vld_p1       <= 1'b0;
      bit_p1       <= 1'b0;
      crc_phase_p1 <= 1'b0;
      done_p1      <= 1'b0;
      if (accept) begin
        crc_q  <= crc_step(crc_q, bus.in_bit);
        cnt_q  <= 3'd7;
        vld_p1 <= 1'b1;
        bit_p1 <= bus.in_bit;
      end else if (state == CRC_OUT) begin
        vld_p1       <= 1'b1;
        crc_phase_p1 <= 1'b1;
        bit_p1       <= crc_q[cnt_q];
        cnt_q        <= cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          done_p1 <= 1'b1;
          crc_q   <= INIT;
        end
      end
    end
  end

  assign bus.in_ready      = (state != CRC_OUT);
  assign bus.out_valid     = vld_p1;
  assign bus.out_bit       = bit_p1;
  assign bus.out_crc_phase = crc_phase_p1;
  assign bus.frame_done    = done_p1;
  assign bus.crc           = crc_q;

endmodule

// File: tb/tb_serial_crc8.sv
// Directed and randomized frames for serial_crc8, checked against a CRC model
// computed by polynomial long division of the augmented message.
`timescale 1ns/1ps
module tb_serial_crc8;
  typedef logic bq_t[$];
  typedef int   iq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  serial_crc8_if bus();

  serial_crc8 #(.POLY(8'h07), .INIT(8'h00)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [34:0] mon_q[$];
  logic [7:0]  crc_hist[int];
  logic        rdy_hist[int];
  int          acc_q[$];
  logic        sent_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output stream capture: one entry {cycle, bit, crc_phase, frame_done} per valid beat.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1)
      mon_q.push_back({cyc[31:0], bus.out_bit, bus.out_crc_phase, bus.frame_done});
    if (bus.frame_done === 1'b1) done_cnt++;
    crc_hist[cyc] = bus.crc;
    rdy_hist[cyc] = bus.in_ready;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: remainder of M(x)*x^8 divided by x^8 + POLY.
  function automatic logic [7:0] crc_model(input bq_t msg);
    logic [8:0] gen;
    logic       m[$];
    logic [7:0] r;
    gen = {1'b1, 8'h07};
    m = msg;
    for (int i = 0; i < 8; i++) m.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (m[i]) for (int k = 0; k <= 8; k++) m[i+k] = m[i+k] ^ gen[8-k];
    for (int k = 0; k < 8; k++) r[7-k] = m[msg.size()+k];
    return r;
  endfunction

  function automatic bq_t byte_bits(input logic [7:0] v);
    bq_t q;
    for (int i = 7; i >= 0; i--) q.push_back(v[i]);
    return q;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic b, input logic last, input int gap);
    int w;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'($urandom);
      bus.in_last  = 1'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_last  = last;
    w = 0;
    #1;
    while (bus.in_ready !== 1'b1 && w < 30) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 30) chk("ready_timeout", 64'd0, 64'd1);
    acc_q.push_back(cyc);
    sent_q.push_back(b);
    @(posedge clk);
  endtask

  task automatic drive_frame(input bq_t bits, input iq_t gaps);
    for (int i = 0; i < bits.size(); i++)
      drive_bit(bits[i], (i == bits.size() - 1), (i < gaps.size()) ? gaps[i] : 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int n, input logic [7:0] exp_crc);
    int w, a, last_acc, low;
    logic b;
    logic [34:0] o;
    w = 0;
    while (mon_q.size() < n + 8 && w < 300) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (mon_q.size() < n + 8 || acc_q.size() < n) begin
      chk({tag, "_stream_timeout"}, 64'(mon_q.size()), 64'(n + 8));
      mon_q.delete(); acc_q.delete(); sent_q.delete();
      return;
    end
    last_acc = 0;
    for (int i = 0; i < n; i++) begin
      a = acc_q.pop_front();
      b = sent_q.pop_front();
      o = mon_q.pop_front();
      chk({tag, "_data"}, 64'(o), 64'({a[31:0] + 32'd1, b, 1'b0, 1'b0}));
      last_acc = a;
    end
    for (int j = 0; j < 8; j++) begin
      o = mon_q.pop_front();
      chk({tag, "_crcbit"}, 64'(o),
          64'({last_acc[31:0] + 32'd2 + 32'(j), exp_crc[7-j], 1'b1, (j == 7)}));
    end
    for (int k = 1; k <= 8; k++)
      chk({tag, "_crc_snap"}, 64'(crc_hist[last_acc + k]), 64'(exp_crc));
    chk({tag, "_crc_reload"}, 64'(crc_hist[last_acc + 9]), 64'h00);
    low = 0;
    for (int k = 0; k <= 9; k++) if (rdy_hist[last_acc + k] === 1'b0) low++;
    chk({tag, "_ready_low"}, 64'(low), 64'd8);
  endtask

  initial begin
    bq_t bits, b2;
    iq_t gaps, nogaps;
    int  w, dc;
    logic [7:0] digits [9];

    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_last  = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_bit", 64'(bus.out_bit), 64'd0);
    chk("rst_crc_phase", 64'(bus.out_crc_phase), 64'd0);
    chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
    chk("rst_crc", 64'(bus.crc), 64'h00);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Byte 0x01 -> CRC 0x07
    drive_frame(byte_bits(8'h01), nogaps);
    check_frame("b01", 8, 8'h07);

    // Byte 0x80 -> CRC 0x89
    idle(2);
    drive_frame(byte_bits(8'h80), nogaps);
    check_frame("b80", 8, 8'h89);

    // "123456789" -> CRC 0xF4
    idle(1);
    digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    bits.delete();
    for (int i = 0; i < 9; i++) begin
      b2 = byte_bits(digits[i]);
      for (int k = 0; k < 8; k++) bits.push_back(b2[k]);
    end
    drive_frame(bits, nogaps);
    check_frame("check_str", 72, 8'hF4);

    // 0x80 with a 3-cycle valid gap after bit 4, then input noise during CRC_OUT
    idle(2);
    gaps = '{0, 0, 0, 0, 3};
    drive_frame(byte_bits(8'h80), gaps);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.in_bit   = 1'($urandom);
      bus.in_last  = 1'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_frame("gap80", 8, 8'h89);
    idle(4);
    chk("gap80_no_extra", 64'(mon_q.size()), 64'd0);

    // Reset while CRC bit 3 is on out_bit
    drive_frame(byte_bits(8'h01), nogaps);
    w = 0;
    while (mon_q.size() < 13 && w < 40) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("midrst_reach_bit3", 64'(mon_q.size()), 64'd13);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_bit", 64'(bus.out_bit), 64'd0);
    chk("midrst_crc_phase", 64'(bus.out_crc_phase), 64'd0);
    chk("midrst_frame_done", 64'(bus.frame_done), 64'd0);
    chk("midrst_crc", 64'(bus.crc), 64'h00);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    mon_q.delete(); acc_q.delete(); sent_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);
    chk("midrst_no_stream", 64'(mon_q.size()), 64'd0);
    chk("midrst_no_done", 64'(done_cnt), 64'(dc));
    drive_frame(byte_bits(8'h01), nogaps);
    check_frame("after_rst", 8, 8'h07);

    // Back-to-back: second frame's first bit waits for the frame_done cycle
    idle(1);
    drive_frame(byte_bits(8'h01), nogaps);
    drive_frame(byte_bits(8'h80), nogaps);
    if (acc_q.size() == 16)
      chk("b2b_first_accept", 64'(acc_q[8]), 64'(acc_q[7] + 9));
    else
      chk("b2b_accept_count", 64'(acc_q.size()), 64'd16);
    check_frame("b2b_a", 8, 8'h07);
    check_frame("b2b_b", 8, 8'h89);

    // Single-bit frames (IDLE straight to CRC_OUT)
    idle(2);
    bits = '{1'b1};
    drive_frame(bits, nogaps);
    check_frame("onebit1", 1, crc_model(bits));
    bits = '{1'b0};
    drive_frame(bits, nogaps);
    check_frame("onebit0", 1, crc_model(bits));

    // Randomized frames with random lengths and valid gaps
    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(1, 24);
      bits.delete();
      gaps.delete();
      for (int i = 0; i < len; i++) begin
        bits.push_back(1'($urandom));
        gaps.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      idle($urandom_range(0, 3));
      drive_frame(bits, gaps);
      check_frame("rand", len, crc_model(bits));
    end

    idle(4);
    chk("end_stream_empty", 64'(mon_q.size()), 64'd0);
    chk("end_accept_empty", 64'(acc_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
